// File: rtl/tr_step_gen.sv
// Tracking-mode stepper controller: bands |x - x0| into a step period, generates the
// drv_step pulse train, holds inside a deadzone and inserts a settle gap on reversal.
//
// state  | meaning
// IDLE   | tracking disabled, driver off
// TRACK  | issuing step pulses at the band period
// HOLD   | on target, driver off until |dx| leaves the deadzone
// SETTLE | direction just changed, step held low for DIR_SETTLE clk
module tr_step_gen #(
  parameter int WIDTH_IN   = 16,
  parameter int WIDTH_PER  = 17,
  parameter int WIDTH_CNT  = 16,
  parameter int DEADZONE   = 9,
  parameter int PULSE_W    = 50,
  parameter int DIR_SETTLE = 50,
  parameter int PER_FAR    = 800,
  parameter int PER_MID    = 39600,
  parameter int PER_NEAR   = 80000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tr_mode_enable,
  input  logic                 data_valid,
  input  logic [WIDTH_IN-1:0]  x,
  input  logic [WIDTH_IN-1:0]  x0,
  input  logic [WIDTH_IN-1:0]  dx1,
  input  logic [WIDTH_IN-1:0]  dx2,
  output logic                 drv_step,
  output logic                 drv_dir,
  output logic                 drv_enable_SM,
  output logic [WIDTH_PER-1:0] period,
  output logic [WIDTH_CNT-1:0] step_count,
  output logic [1:0]           state
);

  localparam int SW = $clog2(DIR_SETTLE + 1);
  localparam logic [WIDTH_PER-1:0] P_FAR  = WIDTH_PER'(PER_FAR);
  localparam logic [WIDTH_PER-1:0] P_MID  = WIDTH_PER'(PER_MID);
  localparam logic [WIDTH_PER-1:0] P_NEAR = WIDTH_PER'(PER_NEAR);
  localparam logic [WIDTH_PER-1:0] P_PW   = WIDTH_PER'(PULSE_W);
  localparam logic [WIDTH_PER-1:0] P_ONE  = WIDTH_PER'(1);
  localparam logic [WIDTH_IN-1:0]  DZ     = WIDTH_IN'(DEADZONE);
  localparam logic [SW-1:0]        S_LOAD = SW'(DIR_SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_HOLD   = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t               st, st_nxt;
  logic [WIDTH_IN-1:0]  mag, diff_abs;
  logic                 sgn;
  logic [WIDTH_PER-1:0] band_per, band_new;
  logic [WIDTH_PER-1:0] pcnt, pcnt_nxt, per_nxt;
  logic [SW-1:0]        scnt, scnt_nxt;
  logic                 dir_nxt, en_nxt, step_nxt, wrap;

  assign state = st;

  always_comb begin
    diff_abs = (x > x0) ? (x - x0) : (x0 - x);
    if (diff_abs >= dx2)      band_new = P_FAR;
    else if (diff_abs >= dx1) band_new = P_MID;
    else if (diff_abs != '0)  band_new = P_NEAR;
    else                      band_new = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag      <= '0;
      sgn      <= 1'b0;
      band_per <= '0;
    end else if (data_valid) begin
      mag      <= diff_abs;
      sgn      <= (x <= x0);
      band_per <= band_new;
    end
  end

  assign wrap = (pcnt == period - P_ONE);

  always_comb begin
    st_nxt   = st;
    dir_nxt  = drv_dir;
    en_nxt   = drv_enable_SM;
    pcnt_nxt = pcnt;
    per_nxt  = period;
    scnt_nxt = scnt;
    step_nxt = 1'b0;
    if (!tr_mode_enable) begin
      st_nxt   = S_IDLE;
      en_nxt   = 1'b0;
      pcnt_nxt = '0;
      per_nxt  = '0;
    end else begin
      case (st)
        S_IDLE, S_HOLD: begin
          if (st == S_IDLE && mag == '0) begin
            st_nxt = S_HOLD;
            en_nxt = 1'b0;
          end else if (st == S_IDLE || mag >= DZ) begin
            en_nxt = 1'b1;
            if (sgn != drv_dir) begin
              st_nxt   = S_SETTLE;
              dir_nxt  = sgn;
              scnt_nxt = S_LOAD;
            end else begin
              st_nxt   = S_TRACK;
              pcnt_nxt = '0;
              per_nxt  = band_per;
            end
          end
        end
        S_TRACK: begin
          step_nxt = (pcnt < P_PW);
          if (wrap) begin
            pcnt_nxt = '0;
            if (mag == '0) begin
              st_nxt  = S_HOLD;
              en_nxt  = 1'b0;
              per_nxt = '0;
            end else if (sgn != drv_dir) begin
              st_nxt   = S_SETTLE;
              dir_nxt  = sgn;
              scnt_nxt = S_LOAD;
              per_nxt  = '0;
            end else begin
              per_nxt = band_per;
            end
          end else begin
            pcnt_nxt = pcnt + P_ONE;
          end
        end
        default: begin
          // A reversal during the gap restarts it so the driver always sees a full settle.
          if (sgn != drv_dir) begin
            dir_nxt  = sgn;
            scnt_nxt = S_LOAD;
          end else if (scnt == '0) begin
            if (mag == '0) begin
              st_nxt = S_HOLD;
              en_nxt = 1'b0;
            end else begin
              st_nxt   = S_TRACK;
              pcnt_nxt = '0;
              per_nxt  = band_per;
            end
          end else begin
            scnt_nxt = scnt - SW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= S_IDLE;
      drv_dir       <= 1'b0;
      drv_enable_SM <= 1'b0;
      drv_step      <= 1'b0;
      pcnt          <= '0;
      period        <= '0;
      scnt          <= '0;
      step_count    <= '0;
    end else begin
      st            <= st_nxt;
      drv_dir       <= dir_nxt;
      drv_enable_SM <= en_nxt;
      drv_step      <= step_nxt;
      pcnt          <= pcnt_nxt;
      period        <= per_nxt;
      scnt          <= scnt_nxt;
      if (step_nxt && !drv_step)
        step_count <= step_count + WIDTH_CNT'(1);
    end
  end

endmodule

// File: tb/tb_tr_step_gen.sv
// Bench for tr_step_gen: vector table from IDLE, directed multi-cycle sequences and a
// randomized run checked against a target/hysteresis model plus a pulse-train monitor.
module tb_tr_step_gen;

  localparam int DEADZONE   = 9;
  localparam int PULSE_W    = 50;
  localparam int DIR_SETTLE = 50;
  localparam int PER_FAR    = 800;
  localparam int PER_MID    = 39600;
  localparam int PER_NEAR   = 80000;

  logic        clk = 1'b0;
  logic        rst, en, dv;
  logic [15:0] x, x0, dx1, dx2;
  logic        drv_step, drv_dir, drv_en;
  logic [16:0] period;
  logic [15:0] step_count;
  logic [1:0]  state;

  tr_step_gen dut (
    .clk(clk), .rst(rst), .tr_mode_enable(en), .data_valid(dv),
    .x(x), .x0(x0), .dx1(dx1), .dx2(dx2),
    .drv_step(drv_step), .drv_dir(drv_dir), .drv_enable_SM(drv_en),
    .period(period), .step_count(step_count), .state(state)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sample(input logic [15:0] xv, input logic [15:0] x0v);
    x  = xv;
    x0 = x0v;
    dv = 1'b1;
    tick();
    dv = 1'b0;
  endtask

  task automatic do_reset();
    en  = 1'b0;
    dv  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_step(input logic v, input int maxc, output int c);
    c = 0;
    while (drv_step !== v && c < maxc) begin
      tick();
      c++;
    end
    check("wait_step_level", longint'(drv_step), longint'(v));
  endtask

  task automatic wait_state(input logic [1:0] s, input int maxc, output int c);
    c = 0;
    while (state !== s && c < maxc) begin
      tick();
      c++;
    end
    check("wait_state_value", longint'(state), longint'(s));
  endtask

  // Pulse-train monitor used during the randomized run.
  logic mon_en = 1'b0;
  logic prev_step, prev_dir;
  int   rises, hi_len, last_rise, last_dir_chg;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (drv_step) begin
        if (!prev_step) begin
          rises++;
          if (last_rise >= 0)
            check("rise_spacing_ge_far", longint'(cycle - last_rise >= PER_FAR), 1);
          check("settle_gap_after_dir", longint'(cycle - last_dir_chg > DIR_SETTLE), 1);
          last_rise = cycle;
          hi_len = 0;
        end
        hi_len++;
      end else if (prev_step) begin
        check("pulse_width", hi_len, PULSE_W);
      end
      if (drv_dir !== prev_dir) last_dir_chg = cycle;
      prev_step = drv_step;
      prev_dir  = drv_dir;
    end
  end

  typedef struct {
    logic [15:0] x, x0, dx1, dx2;
    logic [1:0]  st;
    logic        dir;
    logic [16:0] per;
    logic        en;
  } vec_t;

  vec_t vt[10];

  initial begin
    int c, r1, r2, r3, s, t, h;
    bit holding, dir_m, sgn_m;
    int mag, x0r, xr;
    logic [15:0] sc0, sc_delta;

    x = '0; x0 = '0; dx1 = 16'd10; dx2 = 16'd100; en = 1'b0; dv = 1'b0; rst = 1'b0;

    vt[0] = '{16'd1000,  16'd800,   16'd10,  16'd100, 2'd1, 1'b0, 17'(PER_FAR),  1'b1};
    vt[1] = '{16'd850,   16'd800,   16'd10,  16'd100, 2'd1, 1'b0, 17'(PER_MID),  1'b1};
    vt[2] = '{16'd805,   16'd800,   16'd10,  16'd100, 2'd1, 1'b0, 17'(PER_NEAR), 1'b1};
    vt[3] = '{16'd800,   16'd800,   16'd10,  16'd100, 2'd2, 1'b0, 17'd0,         1'b0};
    vt[4] = '{16'd700,   16'd800,   16'd10,  16'd100, 2'd3, 1'b1, 17'd0,         1'b1};
    vt[5] = '{16'd900,   16'd800,   16'd100, 16'd200, 2'd1, 1'b0, 17'(PER_MID),  1'b1};
    vt[6] = '{16'd899,   16'd800,   16'd100, 16'd200, 2'd1, 1'b0, 17'(PER_NEAR), 1'b1};
    vt[7] = '{16'd1000,  16'd800,   16'd100, 16'd200, 2'd1, 1'b0, 17'(PER_FAR),  1'b1};
    vt[8] = '{16'd65535, 16'd0,     16'd10,  16'd100, 2'd1, 1'b0, 17'(PER_FAR),  1'b1};
    vt[9] = '{16'd0,     16'd65535, 16'd10,  16'd100, 2'd3, 1'b1, 17'd0,         1'b1};

    // Reset state
    rst = 1'b1;
    #5;
    check("reset_state", longint'(state), 0);
    check("reset_step_count", longint'(step_count), 0);
    check("reset_outputs", longint'({drv_step, drv_dir, drv_en}), 0);
    check("reset_period", longint'(period), 0);
    tick();
    rst = 1'b0;

    // Vector table: sample with enable low, then enable and look one clk later.
    foreach (vt[i]) begin
      do_reset();
      dx1 = vt[i].dx1;
      dx2 = vt[i].dx2;
      sample(vt[i].x, vt[i].x0);
      en = 1'b1;
      tick();
      check($sformatf("vec%0d_state", i),  longint'(state),  longint'(vt[i].st));
      check($sformatf("vec%0d_dir", i),    longint'(drv_dir), longint'(vt[i].dir));
      check($sformatf("vec%0d_period", i), longint'(period), longint'(vt[i].per));
      check($sformatf("vec%0d_enable", i), longint'(drv_en), longint'(vt[i].en));
    end
    dx1 = 16'd10;
    dx2 = 16'd100;

    // Async reset in the middle of a pulse
    do_reset();
    sample(16'd1000, 16'd800);
    en = 1'b1;
    tick();
    wait_step(1'b1, 5, c);
    ticks(10);
    #3 rst = 1'b1;
    #1;
    check("midpulse_rst_state", longint'(state), 0);
    check("midpulse_rst_outputs", longint'({drv_step, drv_dir, drv_en}), 0);
    check("midpulse_rst_period", longint'(period), 0);
    check("midpulse_rst_count", longint'(step_count), 0);
    tick();
    rst = 1'b0;

    // Far band pulse train, then mid-period band change
    do_reset();
    sample(16'd1000, 16'd800);
    en = 1'b1;
    tick();
    check("track_entry_state", longint'(state), 1);
    check("track_entry_step_low", longint'(drv_step), 0);
    wait_step(1'b1, 5, c);
    check("first_rise_delay", c, 1);
    r1 = cycle;
    wait_step(1'b0, 100, c);
    check("pulse_high_clk", c, PULSE_W);
    wait_step(1'b1, 1000, c);
    r2 = cycle;
    check("far_rise_spacing", r2 - r1, PER_FAR);
    check("step_count_two", longint'(step_count), 2);
    ticks(100);
    sample(16'd850, 16'd800);
    ticks(5);
    check("period_kept_until_wrap", longint'(period), PER_FAR);
    wait_step(1'b0, 100, c);
    wait_step(1'b1, 1000, c);
    r3 = cycle;
    check("no_truncated_period", r3 - r2, PER_FAR);
    check("mid_period_adopted", longint'(period), PER_MID);
    check("step_count_three", longint'(step_count), 3);

    // On target -> HOLD at wrap; deadzone hysteresis; leave at DEADZONE; then disable
    do_reset();
    sample(16'd1000, 16'd800);
    en = 1'b1;
    tick();
    wait_step(1'b1, 5, c);
    r1 = cycle;
    ticks(200);
    sample(16'd800, 16'd800);
    wait_state(2'd2, 900, c);
    h = cycle;
    check("hold_at_wrap", h - r1, PER_FAR - 1);
    check("hold_enable", longint'(drv_en), 0);
    check("hold_period", longint'(period), 0);
    sample(16'd805, 16'd800);
    ticks(10);
    check("deadzone_5_hold", longint'(state), 2);
    sample(16'd808, 16'd800);
    ticks(10);
    check("deadzone_8_hold", longint'(state), 2);
    sample(16'(800 + DEADZONE), 16'd800);
    tick();
    check("deadzone_exit_state", longint'(state), 1);
    check("deadzone_exit_enable", longint'(drv_en), 1);
    check("deadzone_exit_period", longint'(period), PER_NEAR);
    wait_step(1'b1, 5, c);
    ticks(3);
    en = 1'b0;
    tick();
    check("disable_step", longint'(drv_step), 0);
    check("disable_enable", longint'(drv_en), 0);
    check("disable_state", longint'(state), 0);
    check("disable_period", longint'(period), 0);

    // Reversal: finish period, settle gap, re-enter TRACK
    do_reset();
    sample(16'd1000, 16'd800);
    en = 1'b1;
    tick();
    wait_step(1'b1, 5, c);
    r1 = cycle;
    ticks(20);
    sample(16'd700, 16'd800);
    check("reversal_pulse_continues", longint'(drv_step), 1);
    wait_state(2'd3, 900, c);
    s = cycle;
    check("settle_at_wrap", s - r1, PER_FAR - 1);
    check("settle_dir", longint'(drv_dir), 1);
    check("settle_step_low", longint'(drv_step), 0);
    wait_state(2'd1, 100, c);
    t = cycle;
    check("settle_length", t - s, DIR_SETTLE);
    wait_step(1'b1, 5, c);
    check("post_settle_first_rise", c, 1);
    check("post_settle_rise_time", cycle - r1, PER_FAR + DIR_SETTLE);

    // Randomized run against a target/hysteresis model
    do_reset();
    en = 1'b1;
    tick();
    holding = 1'b1;
    dir_m   = 1'b0;
    prev_step = drv_step;
    prev_dir  = drv_dir;
    rises = 0; hi_len = 0; last_rise = -1; last_dir_chg = -1000;
    sc0 = step_count;
    mon_en = 1'b1;
    for (int it = 0; it < 24; it++) begin
      int cat;
      cat = int'($urandom_range(0, 3));
      if (cat == 0)                 mag = 0;
      else if (cat == 1 && holding) mag = int'($urandom_range(1, DEADZONE - 1));
      else                          mag = int'($urandom_range(100, 3000));
      x0r = int'($urandom_range(4000, 60000));
      xr  = ($urandom_range(0, 1) == 1) ? x0r - mag : x0r + mag;
      sample(16'(xr), 16'(x0r));
      sgn_m = (xr <= x0r);
      if (mag == 0)                         holding = 1'b1;
      else if (!(holding && mag < DEADZONE)) begin
        holding = 1'b0;
        dir_m   = sgn_m;
      end
      ticks(PER_FAR + DIR_SETTLE + 10);
      check($sformatf("rnd%0d_state", it),  longint'(state),  holding ? 2 : 1);
      check($sformatf("rnd%0d_period", it), longint'(period), holding ? 0 : PER_FAR);
      check($sformatf("rnd%0d_enable", it), longint'(drv_en), holding ? 0 : 1);
      check($sformatf("rnd%0d_dir", it),    longint'(drv_dir), longint'(dir_m));
    end
    mon_en = 1'b0;
    sc_delta = step_count - sc0;
    check("rnd_step_count", longint'(sc_delta), longint'(16'(rises)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
